// File: rtl/snake_dir_input.sv
// snake_dir_input: key synchroniser/debouncer with press pulses and a no-reversal, tick-committed snake direction
module snake_dir_input #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       restart,
  input  logic       sw_up,
  input  logic       sw_down,
  input  logic       sw_left,
  input  logic       sw_right,
  input  logic       move_tick,
  output logic [3:0] key_level,
  output logic [3:0] key_pulse,
  output logic [1:0] dir_out,
  output logic       dir_changed
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [3:0] raw, sync1, sync2;
  logic [CNT_W-1:0] cnt [4];
  logic [1:0] pending, cand, ref_dir;
  logic pending_valid, commit, accept;
  assign raw = {sw_up, sw_down, sw_left, sw_right};
  always_ff @(posedge CLOCK_50 or posedge rst)
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      key_level <= '0;
      key_pulse <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int k = 0; k < 4; k++) begin
        key_pulse[k] <= 1'b0;
        if (sync2[k] == key_level[k]) cnt[k] <= '0;
        else if (cnt[k] == LAST) begin
          cnt[k] <= '0;
          key_level[k] <= sync2[k];
          key_pulse[k] <= sync2[k];
        end else cnt[k] <= cnt[k] + 1'b1;
      end
    end
  // Encoding keeps each axis in bit 1, so a same-axis candidate is a repeat or a reversal.
  always_comb begin
    commit = move_tick && pending_valid;
    ref_dir = commit ? pending : dir_out;
    cand = key_pulse[3] ? 2'd0 : key_pulse[2] ? 2'd1 : key_pulse[1] ? 2'd2 : 2'd3;
    accept = |key_pulse && cand[1] != ref_dir[1];
  end
  always_ff @(posedge CLOCK_50 or posedge rst)
    if (rst) begin
      dir_out <= 2'd3;
      pending <= 2'd3;
      pending_valid <= 1'b0;
      dir_changed <= 1'b0;
    end else if (restart) begin
      dir_out <= 2'd3;
      pending_valid <= 1'b0;
      dir_changed <= 1'b0;
    end else begin
      dir_changed <= commit;
      if (commit) dir_out <= pending;
      if (accept) pending <= cand;
      pending_valid <= accept || (pending_valid && !move_tick);
    end
endmodule

// File: tb/tb_snake_dir_input.sv
// tb_snake_dir_input: directed scoreboard bench for snake_dir_input with a short debounce window
module tb_snake_dir_input;
  logic clk = 0, rst = 1, restart = 0, move_tick = 0;
  logic [3:0] sw = '0;
  logic [3:0] key_level, key_pulse;
  logic [1:0] dir_out;
  logic dir_changed;
  typedef struct {
    int cyc;
    string nm;
    logic [3:0] kl;
    logic [3:0] kp;
    logic [1:0] d;
    logic dc;
  } exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0;
  logic [3:0] exp_kl = '0;
  logic [1:0] exp_dir = 2'd3;

  snake_dir_input #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .CLOCK_50(clk), .rst(rst), .restart(restart),
    .sw_up(sw[3]), .sw_down(sw[2]), .sw_left(sw[1]), .sw_right(sw[0]),
    .move_tick(move_tick), .key_level(key_level), .key_pulse(key_pulse),
    .dir_out(dir_out), .dir_changed(dir_changed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk)
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || key_level !== e.kl || key_pulse !== e.kp || dir_out !== e.d || dir_changed !== e.dc) begin
        errors++;
        $display("FAIL %s cyc=%0d/%0d got kl=%b kp=%b dir=%b dc=%b want kl=%b kp=%b dir=%b dc=%b",
                 e.nm, cyc, e.cyc, key_level, key_pulse, dir_out, dir_changed, e.kl, e.kp, e.d, e.dc);
      end
    end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int off, logic [3:0] kl, logic [3:0] kp, logic [1:0] d, logic dc);
    exp_t e;
    e.cyc = cyc + off; e.nm = nm; e.kl = kl; e.kp = kp; e.d = d; e.dc = dc;
    q.push_back(e);
  endtask

  task automatic press(int k, string nm);
    logic [3:0] b;
    b = 4'b1 << k;
    sw[k] = 1'b1;
    chk(nm, 5, exp_kl, 4'b0, exp_dir, 1'b0);
    chk(nm, 6, exp_kl | b, b, exp_dir, 1'b0);
    chk(nm, 7, exp_kl | b, 4'b0, exp_dir, 1'b0);
    exp_kl = exp_kl | b;
    step(8);
    checks++;
    if (key_level !== exp_kl || key_pulse !== 4'b0) begin
      errors++;
      $display("FAIL %s settle got kl=%b kp=%b want kl=%b kp=0000", nm, key_level, key_pulse, exp_kl);
    end
  endtask

  task automatic release_key(int k, string nm);
    sw[k] = 1'b0;
    exp_kl = exp_kl & ~(4'b1 << k);
    chk(nm, 6, exp_kl, 4'b0, exp_dir, 1'b0);
    step(8);
  endtask

  task automatic tick(string nm, logic [1:0] d, logic dc);
    move_tick = 1'b1;
    chk(nm, 1, exp_kl, 4'b0, d, dc);
    chk(nm, 2, exp_kl, 4'b0, d, 1'b0);
    step(1);
    checks++;
    if (dir_out !== d || dir_changed !== dc) begin
      errors++;
      $display("FAIL %s direct got dir=%b dc=%b want dir=%b dc=%b", nm, dir_out, dir_changed, d, dc);
    end
    move_tick = 1'b0;
    exp_dir = d;
    step(2);
  endtask

  task automatic do_restart(string nm);
    restart = 1'b1;
    chk(nm, 1, exp_kl, 4'b0, 2'd3, 1'b0);
    step(1);
    restart = 1'b0;
    exp_dir = 2'd3;
    step(1);
  endtask

  initial begin
    step(2);
    chk("reset", 0, 4'b0, 4'b0, 2'd3, 1'b0);
    step(1);
    rst = 0;
    step(1);
    press(3, "up_press");
    release_key(3, "up_release");
    tick("up_commit", 2'd0, 1'b1);
    sw[1] = 1'b1;
    for (int i = 1; i <= 9; i++) chk("glitch", i, 4'b0, 4'b0, 2'd0, 1'b0);
    step(3);
    sw[1] = 1'b0;
    step(8);
    do_restart("restart");
    press(1, "left_reversal");
    release_key(1, "left_release");
    tick("reversal_tick", 2'd3, 1'b0);
    press(3, "dbl_up");
    release_key(3, "dbl_up_rel");
    press(2, "dbl_down");
    release_key(2, "dbl_down_rel");
    tick("dbl_commit", 2'd1, 1'b1);
    press(3, "up_vs_down");
    release_key(3, "up_vs_down_rel");
    tick("up_rejected", 2'd1, 1'b0);
    do_restart("restart2");
    press(3, "same_up");
    release_key(3, "same_up_rel");
    sw[2] = 1'b1;
    chk("same_down", 6, 4'b0100, 4'b0100, 2'd3, 1'b0);
    step(6);
    move_tick = 1'b1;
    chk("same_commit", 1, 4'b0100, 4'b0, 2'd0, 1'b1);
    step(1);
    move_tick = 1'b0;
    exp_kl = 4'b0100;
    exp_dir = 2'd0;
    step(2);
    release_key(2, "same_down_rel");
    tick("same_down_rejected", 2'd0, 1'b0);
    do_restart("restart3");
    press(3, "left_up");
    release_key(3, "left_up_rel");
    sw[1] = 1'b1;
    chk("same_left", 6, 4'b0010, 4'b0010, 2'd3, 1'b0);
    step(6);
    move_tick = 1'b1;
    chk("left_commit", 1, 4'b0010, 4'b0, 2'd0, 1'b1);
    step(1);
    move_tick = 1'b0;
    exp_kl = 4'b0010;
    exp_dir = 2'd0;
    step(2);
    release_key(1, "left_rel");
    tick("left_pending", 2'd2, 1'b1);
    do_restart("restart4");
    sw[3] = 1'b1;
    sw[1] = 1'b1;
    chk("prio_press", 6, 4'b1010, 4'b1010, 2'd3, 1'b0);
    step(8);
    sw[3] = 1'b0;
    sw[1] = 1'b0;
    chk("prio_rel", 6, 4'b0, 4'b0, 2'd3, 1'b0);
    step(8);
    exp_kl = 4'b0;
    tick("prio_commit", 2'd0, 1'b1);
    do_restart("restart5");
    press(3, "hold_up");
    restart = 1'b1;
    move_tick = 1'b1;
    chk("restart_tick", 1, 4'b1000, 4'b0, 2'd3, 1'b0);
    chk("restart_tick", 2, 4'b1000, 4'b0, 2'd3, 1'b0);
    step(1);
    restart = 1'b0;
    move_tick = 1'b0;
    step(2);
    tick("after_restart", 2'd3, 1'b0);
    release_key(3, "hold_up_rel");
    press(3, "pre_rst_up");
    tick("pre_rst_commit", 2'd0, 1'b1);
    sw[0] = 1'b1;
    step(3);
    rst = 1'b1;
    chk("async_rst", 0, 4'b0, 4'b0, 2'd3, 1'b0);
    step(2);
    sw = '0;
    step(4);
    rst = 1'b0;
    chk("post_rst", 8, 4'b0, 4'b0, 2'd3, 1'b0);
    step(12);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never compared (due cyc=%0d, now %0d)", e.nm, e.cyc, cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
